// File: rtl/reg_list_sequencer_if.sv
// Purpose : bundles the request, beat handshake and status signals of reg_list_sequencer.
// Latency : none; this is a wiring bundle only.
// Backpressure: the ready signal from the memory side stalls beats presented on valid.
// Ports   : slave  = sequencer side (takes start/list/base/up/pre/ready, drives beat + status)
//           master = requester/memory side (mirror image of slave)
interface reg_list_sequencer_if;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        up;
  logic        pre;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [15:0] onehot;
  logic [31:0] addr;
  logic        last;
  logic        done;
  logic [31:0] wb_addr;

  modport slave (
    input  start, reg_list, base_addr, up, pre, ready,
    output busy, valid, onehot, addr, last, done, wb_addr
  );

  modport master (
    output start, reg_list, base_addr, up, pre, ready,
    input  busy, valid, onehot, addr, last, done, wb_addr
  );
endinterface

// File: rtl/reg_list_sequencer.sv
// Purpose : walks an LDM/STM register list, one memory beat per set bit, lowest register first.
// Latency : first beat one cycle after start; done one cycle after the final handshake.
// Backpressure: a beat holds (onehot/addr/last steady) while ready is low; each stall adds a cycle.
// Ports   : clk, reset_n (async active-low)
//           bus (slave modport): start/reg_list/base_addr/up/pre in, ready in,
//           busy/valid/onehot/addr/last/done/wb_addr out
module reg_list_sequencer (
  input  logic                  clk,
  input  logic                  reset_n,
  reg_list_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wb_q, wb_d;

  // Start-cycle arithmetic on the incoming request.
  logic [4:0]  reg_cnt;
  logic [31:0] four_n;
  logic [31:0] base_aligned;
  logic [31:0] start_addr;
  logic [31:0] wb_calc;

  // Beat decode from the registered remaining list.
  logic [15:0] lowest_bit;
  logic        final_beat;

  // The low address bits are dropped on purpose: transfers are word aligned.
  logic unused_base_lsbs;
  assign unused_base_lsbs = ^bus.base_addr[1:0];

  always_comb begin
    reg_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      reg_cnt = reg_cnt + 5'(bus.reg_list[i]);
    end
  end

  assign four_n       = {25'd0, reg_cnt, 2'b00};
  assign base_aligned = {bus.base_addr[31:2], 2'b00};
  assign wb_calc      = bus.up ? (base_aligned + four_n) : (base_aligned - four_n);

  // Beats always ascend, so decrementing modes start at the bottom of the block.
  always_comb begin
    start_addr = base_aligned;
    case ({bus.up, bus.pre})
      2'b10:   start_addr = base_aligned;
      2'b11:   start_addr = base_aligned + 32'd4;
      2'b00:   start_addr = base_aligned - four_n + 32'd4;
      default: start_addr = base_aligned - four_n;
    endcase
  end

  assign lowest_bit = remaining_q & (~remaining_q + 16'd1);
  assign final_beat = (remaining_q & (remaining_q - 16'd1)) == 16'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= 16'd0;
      addr_q      <= 32'd0;
      wb_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      wb_q        <= wb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    wb_d        = wb_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          remaining_d = bus.reg_list;
          addr_d      = start_addr;
          wb_d        = wb_calc;
          state_d     = (bus.reg_list != 16'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (bus.ready) begin
          remaining_d = remaining_q & (remaining_q - 16'd1);
          addr_d      = addr_q + 32'd4;
          if (final_beat) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs come from registered state only; ready never reaches them combinationally.
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.valid   = (state_q == ST_RUN);
  assign bus.onehot  = (state_q == ST_RUN) ? lowest_bit : 16'd0;
  assign bus.last    = (state_q == ST_RUN) && final_beat;
  assign bus.done    = (state_q == ST_DONE);
  assign bus.addr    = addr_q;
  assign bus.wb_addr = wb_q;

endmodule

// File: doc/reg_list_sequencer.md
# reg_list_sequencer

Sequences the 16-bit register list of an LDM/STM instruction into one memory beat per listed register, lowest register first. Each beat presents the one-hot bit of the register being transferred, which drives the `bits` input of the downstream 16-to-4 encoder that produces the register number. Each beat also presents the word address for that transfer. At the end the block reports the base-register writeback value.

## Interface
- No parameters. Address width is fixed at 32; registers are fixed at 16.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a transfer; sampled only in IDLE.
- `reg_list` in 16: register list, bit i = Ri; sampled with `start`.
- `base_addr` in 32: base register value; sampled with `start`.
- `up` in 1: U bit; 1 = increment, 0 = decrement.
- `pre` in 1: P bit; 1 = before, 0 = after.
- `ready` in 1: downstream accepts the current beat.
- `busy` out 1: state is not IDLE.
- `valid` out 1: a beat is presented.
- `onehot` out 16: lowest set bit of the remaining list; 0 when `valid` is 0.
- `addr` out 32: word address of the current beat; bits [1:0] are always 0.
- `last` out 1: the current beat is the final beat.
- `done` out 1: one-cycle pulse at the end of the transfer.
- `wb_addr` out 32: writeback value; stable from the `done` cycle until the next accepted `start`.

## Operation
- **Addressing.** Let A = {base_addr[31:2],2'b00} and n = popcount(reg_list). The start address S is:
  - IA (up=1, pre=0): S = A.
  - IB (up=1, pre=1): S = A+4.
  - DA (up=0, pre=0): S = A-4n+4.
  - DB (up=0, pre=1): S = A-4n.
- **Writeback.** wb_addr = A+4n when up=1, A-4n when up=0.
- **Arithmetic.** All arithmetic is modulo 2^32; wrap-around is silent. n ranges 0..16, so 4n needs 7 bits, zero-extended.
- **Beat order.** Beats always run in ascending register order at ascending addresses S, S+4, … regardless of U.
- **States.**
  - IDLE: when `start`=1, latch the list into `remaining`, load `addr`<=S and `wb_addr`<=computed value. Go to RUN if n>0, else go to DONE.
  - RUN: `valid`=1. `onehot` = remaining & (~remaining+1). `last` = (remaining & (remaining-1)) == 0.
    - On `valid`&&`ready`: clear that bit from `remaining` and set `addr`<=`addr`+4.
    - If `last`, go to DONE.
    - With `ready`=0, all outputs hold.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- **Ignored inputs.** `start` in RUN or DONE is ignored. `reg_list`, `base_addr`, `up` and `pre` are ignored outside the IDLE `start` cycle.
- **Empty list.** reg_list=0 produces no beats, a `done` pulse, and wb_addr=A.
- **Registered outputs.** `busy`, `valid`, `onehot`, `last` and `done` are decoded from registered state and `remaining` only, with no combinational path from inputs. `ready` affects only the next state.

## Timing
- **Reset.** Asynchronous on the falling edge of reset_n, effective immediately. State=IDLE. busy=0, valid=0, onehot=0, addr=0, last=0, done=0, wb_addr=0.
- **Reset mid-operation.** Aborts the transfer immediately; no `done` pulse is produced.
- **Start latency.** `start` sampled at edge k gives the first `valid` in cycle k+1 (after edge k).
- **Beat rate.** With `ready` tied 1: one beat per cycle, n beats in cycles k+1..k+n, `done` in cycle k+n+1, IDLE again in cycle k+n+2.
- **Throughput.** A new `start` is accepted in cycle k+n+2 at the earliest. Each cycle of `ready`=0 adds one cycle.
- **Empty-list timing.** `done` in cycle k+1.
- **Status flags.** `busy` is high from cycle k+1 through the `done` cycle inclusive. `last` and `valid` fall together after the final handshake.

## Test plan
- **IA, two registers.** IA, list 16'h8001, base 32'h1000, ready=1 -> beat 1: onehot 16'h0001 @ 32'h1000; beat 2: onehot 16'h8000 @ 32'h1004 with last=1; done next cycle; wb_addr 32'h1008.
- **DB, four registers.** DB, list 16'h00F0, base 32'h2000 -> onehot 0010/0020/0040/0080 at 1FF0/1FF4/1FF8/1FFC; wb_addr 32'h1FF0; base low bits 2'b11 give an identical result.
- **Backpressure and stray start.** IB, list 16'h0006, base 0, ready low for 3 cycles on beat 1 -> onehot 16'h0002 and addr 32'h4 held steady all 3 cycles. Then beat 2: 16'h0004 @ 32'h8. A `start` pulsed mid-transfer has no effect.
- **Empty list.** reg_list=0, DA, base 32'h3000 -> valid never rises; done in cycle k+1; wb_addr 32'h3000; busy high for exactly one cycle.
- **Full list with wrap.** list 16'hFFFF, IB, base 32'hFFFFFFF0 -> 16 beats, first @ 32'hFFFFFFF4, wraps to 32'h0 on beat 4, last @ 32'h00000030 with onehot 16'h8000; wb_addr 32'h00000030. onehot fed to the encoder yields numbers 0..15 in order.
- **Reset mid-transfer.** reset_n low on beat 3 of a 5-beat transfer -> all outputs 0 immediately, no done pulse. After release a new start runs normally from beat 1.
